// File: rtl/wb_burst_arbiter_if.sv
// Bus bundle for the 3-master burst arbiter: master-side request
// lanes plus the shared downstream port.
interface wb_burst_arbiter_if;
   logic [2:0]  m_cyc_i;
   logic [2:0]  m_stb_i;
   logic [2:0]  m_we_i;
   logic [95:0] m_adr_i;
   logic [95:0] m_dat_i;
   logic [11:0] m_sel_i;
   logic [29:0] m_bl_i;
   logic [2:0]  m_ack_o;
   logic [2:0]  m_err_o;
   logic [31:0] m_dat_o;
   logic        s_cyc_o;
   logic        s_stb_o;
   logic        s_we_o;
   logic [31:0] s_adr_o;
   logic [31:0] s_dat_o;
   logic [3:0]  s_sel_o;
   logic [9:0]  s_bl_o;
   logic        s_bry_o;
   logic        s_ack_i;
   logic [31:0] s_dat_i;
   logic [1:0]  gnt_o;

   modport slave (
      input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_bl_i,
      output m_ack_o, m_err_o, m_dat_o,
      output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
      output s_bl_o, s_bry_o,
      input  s_ack_i, s_dat_i,
      output gnt_o
   );

   modport master (
      output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_bl_i,
      input  m_ack_o, m_err_o, m_dat_o,
      input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
      input  s_bl_o, s_bry_o,
      output s_ack_i, s_dat_i,
      input  gnt_o
   );
endinterface

// File: rtl/wb_burst_arbiter.sv
// Round-robin Wishbone arbiter for icache/dcache/other masters with
// burst-length ownership hold and a per-transfer ack timeout.
module wb_burst_arbiter #(
   parameter int TIMEOUT = 255
) (
   input logic               clk,
   input logic               reset,
   wb_burst_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;

   localparam logic [9:0] TMO = 10'(TIMEOUT);

   state_t     r_state;
   logic [1:0] r_gnt;
   logic [1:0] r_last;
   logic [9:0] r_beat;
   logic [9:0] r_tmo;
   logic [2:0] r_err;
   logic [2:0] r_blk;

   logic [2:0]  w_req;
   logic        w_any;
   logic [1:0]  w_c0;
   logic [1:0]  w_c1;
   logic [1:0]  w_c2;
   logic [1:0]  w_win;
   logic        w_busy;
   logic        w_cyc;
   logic        w_stb;
   logic        w_we;
   logic [31:0] w_adr;
   logic [31:0] w_dat;
   logic [3:0]  w_sel;
   logic [9:0]  w_bl;
   logic [2:0]  w_oh;

   // A master aborted by timeout stays masked until it drops cyc.
   assign w_req  = bus.m_cyc_i & ~r_blk;
   assign w_any  = |w_req;
   assign w_busy = (r_state == BUSY);
   assign w_oh   = 3'b001 << r_gnt;

   always_comb begin
      w_c0 = 2'd0;
      w_c1 = 2'd1;
      w_c2 = 2'd2;
      case (r_last)
         2'd0: begin
            w_c0 = 2'd1;
            w_c1 = 2'd2;
            w_c2 = 2'd0;
         end
         2'd1: begin
            w_c0 = 2'd2;
            w_c1 = 2'd0;
            w_c2 = 2'd1;
         end
         default: begin
            w_c0 = 2'd0;
            w_c1 = 2'd1;
            w_c2 = 2'd2;
         end
      endcase
      if (w_req[w_c0])
         w_win = w_c0;
      else if (w_req[w_c1])
         w_win = w_c1;
      else
         w_win = w_c2;
   end

   always_comb begin
      w_cyc = 1'b0;
      w_stb = 1'b0;
      w_we  = 1'b0;
      w_adr = '0;
      w_dat = '0;
      w_sel = '0;
      w_bl  = '0;
      case (r_gnt)
         2'd0: begin
            w_cyc = bus.m_cyc_i[0];
            w_stb = bus.m_stb_i[0];
            w_we  = bus.m_we_i[0];
            w_adr = bus.m_adr_i[31:0];
            w_dat = bus.m_dat_i[31:0];
            w_sel = bus.m_sel_i[3:0];
            w_bl  = bus.m_bl_i[9:0];
         end
         2'd1: begin
            w_cyc = bus.m_cyc_i[1];
            w_stb = bus.m_stb_i[1];
            w_we  = bus.m_we_i[1];
            w_adr = bus.m_adr_i[63:32];
            w_dat = bus.m_dat_i[63:32];
            w_sel = bus.m_sel_i[7:4];
            w_bl  = bus.m_bl_i[19:10];
         end
         2'd2: begin
            w_cyc = bus.m_cyc_i[2];
            w_stb = bus.m_stb_i[2];
            w_we  = bus.m_we_i[2];
            w_adr = bus.m_adr_i[95:64];
            w_dat = bus.m_dat_i[95:64];
            w_sel = bus.m_sel_i[11:8];
            w_bl  = bus.m_bl_i[29:20];
         end
         default: begin
            w_cyc = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_gnt   <= 2'd0;
         r_last  <= 2'd2;
         r_beat  <= '0;
         r_tmo   <= '0;
         r_err   <= '0;
         r_blk   <= '0;
      end else begin
         r_err <= '0;
         r_blk <= r_blk & bus.m_cyc_i;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_gnt   <= w_win;
                  r_beat  <= '0;
                  r_tmo   <= '0;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               if (bus.s_ack_i) begin
                  r_beat <= r_beat + 10'd1;
                  r_tmo  <= '0;
               end else if (w_stb) begin
                  r_tmo <= r_tmo + 10'd1;
               end
               // Error pulse shows in the cycle after the last stall.
               if (r_tmo == TMO) begin
                  r_state      <= TURN;
                  r_blk[r_gnt] <= w_cyc;
               end else if (!w_cyc) begin
                  r_state <= TURN;
               end else if (!bus.s_ack_i && w_stb &&
                            (r_tmo + 10'd1 == TMO)) begin
                  r_err <= w_oh;
               end
            end
            TURN: begin
               r_last  <= r_gnt;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.s_cyc_o = w_busy;
   assign bus.s_stb_o = w_busy & w_stb;
   assign bus.s_we_o  = w_busy & w_we;
   assign bus.s_adr_o = w_busy ? w_adr : '0;
   assign bus.s_dat_o = w_busy ? w_dat : '0;
   assign bus.s_sel_o = w_busy ? w_sel : '0;
   assign bus.s_bl_o  = w_busy ? w_bl : '0;
   assign bus.s_bry_o = w_busy & w_stb;
   assign bus.m_ack_o = (w_busy & bus.s_ack_i) ? w_oh : '0;
   assign bus.m_err_o = r_err;
   assign bus.m_dat_o = reset ? '0 : bus.s_dat_i;
   assign bus.gnt_o   = r_gnt;

endmodule

// File: tb/tb_wb_burst_arbiter.sv
// Directed bench for wb_burst_arbiter: single read, round robin,
// burst hold, async reset mid-burst, timeout and re-grant masking.
module tb_wb_burst_arbiter;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  wb_burst_arbiter_if bus ();

  wb_burst_arbiter #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] all_out;
  assign all_out = {6'd0, bus.s_cyc_o, bus.s_stb_o,
                    bus.s_we_o, bus.s_adr_o,
                    bus.s_dat_o, bus.s_sel_o,
                    bus.s_bl_o, bus.s_bry_o,
                    bus.m_ack_o, bus.m_err_o,
                    bus.m_dat_o, bus.gnt_o};

  logic [1:0] eg [4];

  task automatic chk(input string tag,
                     input logic [127:0] o,
                     input logic [127:0] e);
    total++;
    if (o !== e) begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic setm(input int k,
                      input logic [31:0] adr,
                      input logic [31:0] dat,
                      input logic [9:0] bl);
    bus.m_adr_i[32*k +: 32] = adr;
    bus.m_dat_i[32*k +: 32] = dat;
    bus.m_sel_i[4*k +: 4]   = 4'hF;
    bus.m_bl_i[10*k +: 10]  = bl;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    eg[0] = 2'd0;
    eg[1] = 2'd1;
    eg[2] = 2'd2;
    eg[3] = 2'd0;
    reset       = 1'b1;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_sel_i = '0;
    bus.m_bl_i  = '0;
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = 32'h0;

    smp();
    chk("rst_all", all_out, 128'd0);
    nxt();
    reset = 1'b0;
    smp();
    chk("post_rst_cyc", bus.s_cyc_o, 1'b0);

    nxt();
    setm(0, 32'h0000_1000, 32'h0, 10'd0);
    bus.m_cyc_i = 3'b001;
    bus.m_stb_i = 3'b001;
    smp();
    chk("rd_idle_cyc", bus.s_cyc_o, 1'b0);
    nxt();
    smp();
    chk("rd_b1_cyc", bus.s_cyc_o, 1'b1);
    chk("rd_b1_gnt", bus.gnt_o, 2'd0);
    chk("rd_b1_adr", bus.s_adr_o, 32'h0000_1000);
    chk("rd_b1_bry", bus.s_bry_o, 1'b1);
    chk("rd_b1_ack", bus.m_ack_o, 3'b000);
    nxt();
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'hDEAD_BEEF;
    bus.m_cyc_i = 3'b000;
    bus.m_stb_i = 3'b000;
    smp();
    chk("rd_b2_ack", bus.m_ack_o, 3'b001);
    chk("rd_b2_dat", bus.m_dat_o, 32'hDEAD_BEEF);
    nxt();
    smp();
    chk("rd_turn_cyc", bus.s_cyc_o, 1'b0);
    chk("rd_turn_stray", bus.m_ack_o, 3'b000);
    nxt();
    smp();
    chk("idle_stray_ack", bus.m_ack_o, 3'b000);
    chk("idle_cyc", bus.s_cyc_o, 1'b0);
    nxt();
    bus.s_ack_i = 1'b0;
    reset = 1'b1;
    smp();
    nxt();
    reset = 1'b0;

    setm(0, 32'h0000_0100, 32'h0, 10'd0);
    setm(1, 32'h0000_0200, 32'h0, 10'd0);
    setm(2, 32'h0000_0300, 32'h0, 10'd0);
    bus.m_cyc_i = 3'b111;
    bus.m_stb_i = 3'b111;
    smp();
    chk("rr_idle_cyc", bus.s_cyc_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      nxt();
      bus.s_ack_i = 1'b1;
      bus.m_cyc_i[eg[i]] = 1'b0;
      smp();
      chk("rr_gnt", bus.gnt_o, eg[i]);
      chk("rr_ack", bus.m_ack_o, 3'b001 << eg[i]);
      chk("rr_adr", bus.s_adr_o,
          32'h100 * (32'(eg[i]) + 32'd1));
      nxt();
      bus.s_ack_i = 1'b0;
      if (i == 3) begin
        setm(1, 32'h0000_2000, 32'h5555_0000, 10'd8);
        bus.m_cyc_i = 3'b011;
        bus.m_stb_i = 3'b011;
      end else begin
        bus.m_cyc_i = 3'b111;
      end
      smp();
      chk("rr_turn_cyc", bus.s_cyc_o, 1'b0);
      nxt();
      smp();
      chk("rr_idle_gap", bus.s_cyc_o, 1'b0);
    end

    for (int b = 0; b < 8; b++) begin
      nxt();
      bus.s_ack_i = 1'b1;
      bus.s_dat_i = 32'(b);
      if (b == 7)
        bus.m_cyc_i = 3'b001;
      smp();
      chk("bh_gnt", bus.gnt_o, 2'd1);
      chk("bh_ack", bus.m_ack_o, 3'b010);
      chk("bh_bl", bus.s_bl_o, 10'd8);
    end
    nxt();
    bus.s_ack_i = 1'b0;
    smp();
    chk("bh_turn_cyc", bus.s_cyc_o, 1'b0);
    nxt();
    smp();
    chk("bh_idle_cyc", bus.s_cyc_o, 1'b0);
    nxt();
    smp();
    chk("bh_ic_cyc", bus.s_cyc_o, 1'b1);
    chk("bh_ic_gnt", bus.gnt_o, 2'd0);
    nxt();
    bus.s_ack_i = 1'b1;
    bus.m_cyc_i = 3'b000;
    smp();
    chk("bh_ic_ack", bus.m_ack_o, 3'b001);
    nxt();
    bus.s_ack_i = 1'b0;

    bus.m_cyc_i = 3'b010;
    bus.m_stb_i = 3'b010;
    nxt();
    smp();
    nxt();
    bus.s_ack_i = 1'b1;
    smp();
    chk("mr_b1_gnt", bus.gnt_o, 2'd1);
    nxt();
    smp();
    nxt();
    smp();
    chk("mr_b3_ack", bus.m_ack_o, 3'b010);
    #1;
    reset = 1'b1;
    bus.m_cyc_i = 3'b011;
    bus.m_stb_i = 3'b011;
    #1;
    chk("mr_all_zero", all_out, 128'd0);
    nxt();
    reset = 1'b0;
    bus.s_ack_i = 1'b0;
    smp();
    chk("mr_rel_idle", bus.s_cyc_o, 1'b0);
    nxt();
    smp();
    chk("mr_first_cyc", bus.s_cyc_o, 1'b1);
    chk("mr_first_gnt", bus.gnt_o, 2'd0);
    nxt();
    bus.s_ack_i = 1'b1;
    bus.m_cyc_i = 3'b000;
    bus.m_stb_i = 3'b000;
    smp();
    chk("mr_first_ack", bus.m_ack_o, 3'b001);
    nxt();
    bus.s_ack_i = 1'b0;

    setm(2, 32'h0000_3000, 32'h0, 10'd0);
    bus.m_cyc_i = 3'b100;
    bus.m_stb_i = 3'b100;
    nxt();
    smp();
    chk("to_idle_cyc", bus.s_cyc_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      nxt();
      smp();
      chk("to_stall_cyc", bus.s_cyc_o, 1'b1);
      chk("to_stall_err", bus.m_err_o, 3'b000);
    end
    nxt();
    smp();
    chk("to_err", bus.m_err_o, 3'b100);
    chk("to_err_gnt", bus.gnt_o, 2'd2);
    nxt();
    smp();
    chk("to_turn_cyc", bus.s_cyc_o, 1'b0);
    chk("to_turn_err", bus.m_err_o, 3'b000);
    for (int i = 0; i < 3; i++) begin
      nxt();
      smp();
      chk("to_blocked", bus.s_cyc_o, 1'b0);
    end
    nxt();
    bus.m_cyc_i = 3'b000;
    smp();
    nxt();
    bus.m_cyc_i = 3'b100;
    smp();
    chk("to_rereq_idle", bus.s_cyc_o, 1'b0);
    nxt();
    smp();
    chk("to_regrant_cyc", bus.s_cyc_o, 1'b1);
    chk("to_regrant_gnt", bus.gnt_o, 2'd2);
    nxt();
    bus.s_ack_i = 1'b1;
    bus.m_cyc_i = 3'b000;
    smp();
    chk("to_regrant_ack", bus.m_ack_o, 3'b100);
    nxt();
    bus.s_ack_i = 1'b0;
    smp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
